// File: rtl/result_unskew.sv
// result_unskew: rebuilds one ARRAY_SIZE x ARRAY_SIZE result matrix from the
// diagonal-skewed layout of a systolic-array result SRAM. Addresses
// 0..2*ARRAY_SIZE-2 each hold one anti-diagonal (i+j == address). After the
// whole matrix has been captured, it is streamed out one row per
// valid/ready handshake.
//
// Lane placement: element (i,j) of diagonal k = i+j sits in lane
// i + max(0, ARRAY_SIZE-1-k). The lanes this rule leaves empty must be zero.
// A nonzero empty lane sets the sticky fmt_err flag. The matrix is still
// built when that happens.
module result_unskew #(
  parameter int ARRAY_SIZE     = 8,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int ADDR_WIDTH     = 6
) (
  input  logic                                 clk,
  input  logic                                 srst,
  input  logic                                 start,
  output logic [ADDR_WIDTH-1:0]                sram_raddr,
  input  logic [ARRAY_SIZE*OUT_DATA_WIDTH-1:0] sram_rdata,
  output logic                                 row_valid,
  input  logic                                 row_ready,
  output logic [$clog2(ARRAY_SIZE)-1:0]        row_idx,
  output logic [ARRAY_SIZE*OUT_DATA_WIDTH-1:0] row_data,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 fmt_err
);

  localparam int LAST_DIAG = 2 * ARRAY_SIZE - 2;
  localparam int DW        = $clog2(2 * ARRAY_SIZE - 1);
  localparam int IW        = $clog2(ARRAY_SIZE);
  localparam int W         = OUT_DATA_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_OUT   = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  state_t                   state_r;
  state_t                   state_nxt_s;

  logic [ADDR_WIDTH-1:0]    sram_raddr_r;
  logic                     cap_valid_r;
  logic [DW-1:0]            cap_diag_r;
  logic [W-1:0]             mat_r [ARRAY_SIZE][ARRAY_SIZE];

  logic                     row_valid_r;
  logic [IW-1:0]            row_idx_r;
  logic [ARRAY_SIZE*W-1:0]  row_data_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     fmt_err_r;

  logic                     accept_start_s;
  logic                     raddr_last_s;
  logic                     hs_s;
  logic                     last_hs_s;
  logic [DW-1:0]            cap_dist_s;
  logic                     cap_bad_s;
  logic [IW-1:0]            load_idx_s;
  logic [ARRAY_SIZE*W-1:0]  load_row_s;

  // Lane of element (i,j) within its diagonal word.
  function automatic int lane_of(input int i, input int j);
    int k;
    k = i + j;
    if (k < ARRAY_SIZE - 1) begin
      return i + (ARRAY_SIZE - 1 - k);
    end else begin
      return i;
    end
  endfunction

  assign accept_start_s = (state_r == ST_IDLE) && start;
  assign raddr_last_s   = (sram_raddr_r == ADDR_WIDTH'(LAST_DIAG));
  assign hs_s           = row_valid_r && row_ready;
  assign last_hs_s      = (state_r == ST_OUT) && hs_s &&
                          (row_idx_r == IW'(ARRAY_SIZE - 1));

  // Next-state logic for the read / drain / output sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (raddr_last_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      ST_DRAIN: state_nxt_s = ST_OUT;
      ST_OUT: begin
        if (last_hs_s) begin
          state_nxt_s = ST_FIN;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      ST_FIN:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Format check: lanes below |k-(ARRAY_SIZE-1)| are empty for diagonal k.
  always_comb begin
    cap_bad_s = 1'b0;
    if (cap_diag_r >= DW'(ARRAY_SIZE - 1)) begin
      cap_dist_s = cap_diag_r - DW'(ARRAY_SIZE - 1);
    end else begin
      cap_dist_s = DW'(ARRAY_SIZE - 1) - cap_diag_r;
    end
    for (int l = 0; l < ARRAY_SIZE; l++) begin
      if ((DW'(l) < cap_dist_s) && (sram_rdata[l*W +: W] != {W{1'b0}})) begin
        cap_bad_s = 1'b1;
      end else begin
        cap_bad_s = cap_bad_s;
      end
    end
  end

  // Row to present next: row 0 when entering OUT, else the following row.
  always_comb begin
    load_row_s = {(ARRAY_SIZE*W){1'b0}};
    if (state_r == ST_DRAIN) begin
      load_idx_s = {IW{1'b0}};
    end else begin
      load_idx_s = row_idx_r + 1'b1;
    end
    for (int j = 0; j < ARRAY_SIZE; j++) begin
      load_row_s[j*W +: W] = mat_r[load_idx_s][j];
    end
  end

  // Read address counter and sticky format-error flag.
  always_ff @(posedge clk) begin
    if (srst) begin
      sram_raddr_r <= {ADDR_WIDTH{1'b0}};
      fmt_err_r    <= 1'b0;
    end else begin
      if (accept_start_s) begin
        sram_raddr_r <= {ADDR_WIDTH{1'b0}};
      end else if ((state_r == ST_READ) && !raddr_last_s) begin
        sram_raddr_r <= sram_raddr_r + 1'b1;
      end
      if (accept_start_s) begin
        fmt_err_r <= 1'b0;
      end else if (cap_valid_r && cap_bad_s) begin
        fmt_err_r <= 1'b1;
      end
    end
  end

  // Capture tag: remembers which diagonal the SRAM returns next cycle.
  always_ff @(posedge clk) begin
    if (srst) begin
      cap_valid_r <= 1'b0;
      cap_diag_r  <= {DW{1'b0}};
    end else begin
      cap_valid_r <= (state_r == ST_READ);
      cap_diag_r  <= sram_raddr_r[DW-1:0];
    end
  end

  // Matrix store: scatter each captured diagonal into its row/column slots.
  always_ff @(posedge clk) begin
    if (srst || accept_start_s) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        for (int j = 0; j < ARRAY_SIZE; j++) begin
          mat_r[i][j] <= {W{1'b0}};
        end
      end
    end else if (cap_valid_r) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        for (int j = 0; j < ARRAY_SIZE; j++) begin
          if (cap_diag_r == DW'(i + j)) begin
            mat_r[i][j] <= sram_rdata[lane_of(i, j)*W +: W];
          end
        end
      end
    end
  end

  // Output side: row stream registers, busy and the done pulse.
  always_ff @(posedge clk) begin
    if (srst) begin
      row_valid_r <= 1'b0;
      row_idx_r   <= {IW{1'b0}};
      row_data_r  <= {(ARRAY_SIZE*W){1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= last_hs_s;
      busy_r <= (state_nxt_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            row_valid_r <= 1'b0;
            row_idx_r   <= {IW{1'b0}};
          end
        end
        ST_DRAIN: begin
          row_valid_r <= 1'b1;
          row_idx_r   <= {IW{1'b0}};
          row_data_r  <= load_row_s;
        end
        ST_OUT: begin
          if (hs_s) begin
            if (last_hs_s) begin
              row_valid_r <= 1'b0;
            end else begin
              row_idx_r  <= row_idx_r + 1'b1;
              row_data_r <= load_row_s;
            end
          end
        end
        default: begin
          row_valid_r <= row_valid_r;
        end
      endcase
    end
  end

  assign sram_raddr = sram_raddr_r;
  assign row_valid  = row_valid_r;
  assign row_idx    = row_idx_r;
  assign row_data   = row_data_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign fmt_err    = fmt_err_r;

endmodule

// File: tb/tb_result_unskew.sv
// Bench for result_unskew: a diagonal-layout SRAM model fed from a golden
// matrix, and a cycle-indexed reference for addresses, row stream, done,
// busy and fmt_err.
module tb_result_unskew;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int AW = 6;

  logic             clk = 1'b0;
  logic             srst;
  logic             start;
  logic [AW-1:0]    sram_raddr;
  logic [N*W-1:0]   sram_rdata = '0;
  logic             row_valid;
  logic             row_ready;
  logic [2:0]       row_idx;
  logic [N*W-1:0]   row_data;
  logic             busy;
  logic             done;
  logic             fmt_err;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0]   gm  [N][N];
  logic [N*W-1:0] mem [16];

  result_unskew #(.ARRAY_SIZE(N), .OUT_DATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .srst(srst), .start(start),
    .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
    .row_valid(row_valid), .row_ready(row_ready), .row_idx(row_idx),
    .row_data(row_data), .busy(busy), .done(done), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM: data for an address appears one cycle later.
  always @(posedge clk) sram_rdata <= mem[sram_raddr[3:0]];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill_index();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        gm[i][j] = 16'(i * 8 + j);
  endtask

  task automatic fill_neg();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        gm[i][j] = 16'hFFFF;
    gm[7][0] = 16'h8000;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        gm[i][j] = 16'($urandom);
  endtask

  // Lay the golden matrix out as diagonals; optionally dirty lane 0 of one
  // diagonal below the main one (lane 0 is empty there).
  task automatic build_sram(input int bad_diag, input logic [15:0] bad_val);
    for (int k = 0; k < 16; k++) mem[k] = '0;
    for (int k = 0; k < 2 * N - 1; k++) begin
      for (int i = 0; i < N; i++) begin
        int j;
        int lane;
        j = k - i;
        if (j >= 0 && j < N) begin
          lane = i + ((N - 1 - k) > 0 ? (N - 1 - k) : 0);
          mem[k][lane*W +: W] = gm[i][j];
        end
      end
    end
    if (bad_diag >= 0) mem[bad_diag][15:0] = bad_val;
  endtask

  function automatic logic [N*W-1:0] exp_row(input int r);
    logic [N*W-1:0] v;
    for (int j = 0; j < N; j++) v[j*W +: W] = gm[r][j];
    return v;
  endfunction

  // One full frame from start to the cycle after done.
  // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic run_frame(input int rdy_mode, input bit stray, input int bad_diag, output int done_at);
    int  acc;
    bit  finished;
    bit  exp_valid;
    bit  rdy;
    acc = 0;
    done_at = -1;
    finished = 1'b0;
    start = 1'b1;
    row_ready = 1'b0;
    @(posedge clk);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      start = 1'b0;
      exp_valid = (n >= 16) && (acc < N);
      check_val("row_valid", row_valid, exp_valid);
      check_val("busy", busy, !(done_at >= 0 && n > done_at));
      check_val("done", done, (n == done_at));
      check_val("fmt_err", fmt_err, (bad_diag >= 0) && (n >= bad_diag + 2));
      if (n <= 16) check_val("raddr", sram_raddr, (n > 14) ? 14 : n);
      if (exp_valid) begin
        check_val("row_idx", row_idx, acc);
        check_val("row_data", row_data, exp_row(acc));
      end
      if (done_at >= 0 && n == done_at + 1) begin
        finished = 1'b1;
        break;
      end
      start = stray && (n == 4 || n == 19);
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = ((n % 4) == 0) || ((n % 4) == 3);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      row_ready = rdy;
      if (exp_valid && rdy) begin
        acc++;
        if (acc == N) done_at = n + 1;
      end
      @(posedge clk);
    end
    check_val("frame_end", finished, 1'b1);
  endtask

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_raddr"}, sram_raddr, 0);
    check_val({tag, "_valid"}, row_valid, 0);
    check_val({tag, "_idx"}, row_idx, 0);
    check_val({tag, "_data"}, row_data, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_fmt"}, fmt_err, 0);
  endtask

  // Start a frame and hit srst so that it is sampled at edge E<k>.
  task automatic reset_mid(input int k, input string tag);
    start = 1'b1;
    row_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (k - 1) @(posedge clk);
    @(negedge clk);
    srst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
    check_idle_zero(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int bad;
    logic [15:0] bval;
    srst = 1'b1;
    start = 1'b0;
    row_ready = 1'b0;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
    check_idle_zero("reset");

    // Index matrix, always ready: minimum latency.
    fill_index();
    build_sram(-1, 16'h0000);
    run_frame(0, 1'b0, -1, d);
    check_val("latency", d, 24);
    check_val("row3_const", exp_row(3),
              {16'd31, 16'd30, 16'd29, 16'd28, 16'd27, 16'd26, 16'd25, 16'd24});

    // Back-pressure pattern.
    run_frame(1, 1'b0, -1, d);

    // Negative values, bit exact.
    fill_neg();
    build_sram(-1, 16'h0000);
    run_frame(0, 1'b0, -1, d);

    // Dirty unused lane on diagonal 0, then a clean frame clears the flag.
    fill_index();
    build_sram(0, 16'h0001);
    run_frame(0, 1'b0, 0, d);
    build_sram(-1, 16'h0000);
    run_frame(0, 1'b0, -1, d);

    // Stray start pulses while busy are ignored.
    run_frame(0, 1'b1, -1, d);
    check_val("latency_stray", d, 24);

    // Reset mid-READ (with fmt_err already set) and mid-OUT.
    build_sram(0, 16'h0001);
    reset_mid(8, "rst_read");
    build_sram(-1, 16'h0000);
    run_frame(0, 1'b0, -1, d);
    check_val("latency_rst1", d, 24);
    reset_mid(18, "rst_out");
    run_frame(0, 1'b0, -1, d);
    check_val("latency_rst2", d, 24);

    // Random matrices, random back-pressure, occasional format errors.
    for (int f = 0; f < 6; f++) begin
      fill_rand();
      bad  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
      bval = 16'($urandom_range(1, 65535));
      build_sram(bad, bval);
      run_frame(2, 1'b0, bad, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
